// File: rtl/bootprom_ctl_if.sv
// CPU-side bus bundle for the boot PROM controller: strobes, decode hit,
// word address, read data, drive enable and the DTACK/BERR acknowledges.
interface bootprom_ctl_if;
    logic        as_n;
    logic        uds_n;
    logic        lds_n;
    logic        rw;
    logic        prom_sel;
    logic [14:0] cpu_addr;
    logic [15:0] cpu_dout;
    logic        cpu_doe;
    logic        dtack_n;
    logic        berr_n;

    modport master (
        output as_n, uds_n, lds_n, rw, prom_sel, cpu_addr,
        input  cpu_dout, cpu_doe, dtack_n, berr_n
    );

    modport slave (
        input  as_n, uds_n, lds_n, rw, prom_sel, cpu_addr,
        output cpu_dout, cpu_doe, dtack_n, berr_n
    );
endinterface

// File: rtl/bootprom_ctl.sv
// Boot PROM pair read sequencer (27256 high/low bytes, 32K x 16) with DTACK generation.
// Optional macro BOOTPROM_WRITE_BERR_EN: write hits answer with BERR_n instead of DTACK_n.
module bootprom_ctl #(
    parameter int WAIT_STATES = 3,
    parameter int SETUP_CLKS  = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    bootprom_ctl_if.slave  bus,
    output logic [14:0]    prom_addr,
    output logic           prom_ce_n,
    output logic           prom_oe_n,
    input  logic [15:0]    prom_d,
    output logic           busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_LATCH  = 3'd3;
    localparam logic [2:0] S_ACK    = 3'd4;
`ifdef BOOTPROM_WRITE_BERR_EN
    localparam logic [2:0] S_BERR   = 3'd5;
`endif

    logic [2:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_as_hi;
    logic        r_wr;
    logic [14:0] r_addr;
    logic [15:0] r_dout;
    logic        w_start;

    // r_as_hi remembers as_n from the previous edge, so a strobe held low
    // through the end of a cycle can never re-trigger another one.
    assign w_start = (r_state == S_IDLE) && r_as_hi && !bus.as_n && bus.prom_sel &&
                     (!bus.uds_n || !bus.lds_n);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_as_hi <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= 15'd0;
            r_dout  <= 16'h0000;
        end else begin
            r_as_hi <= bus.as_n;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addr <= bus.cpu_addr;
                        r_wr   <= !bus.rw;
                        if (bus.rw) begin
                            r_state <= S_SETUP;
                            r_cnt   <= 4'(SETUP_CLKS - 1);
                        end else begin
`ifdef BOOTPROM_WRITE_BERR_EN
                            r_state <= S_BERR;
`else
                            r_state <= S_ACK;
`endif
                        end
                    end
                end
                S_SETUP: begin
                    if (bus.as_n) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= S_ACCESS;
                        r_cnt   <= 4'(WAIT_STATES - 1);
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    if (bus.as_n) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= S_LATCH;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_LATCH: begin
                    if (bus.as_n) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_dout  <= prom_d;
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (bus.as_n) r_state <= S_IDLE;
                end
`ifdef BOOTPROM_WRITE_BERR_EN
                S_BERR: begin
                    if (bus.as_n) r_state <= S_IDLE;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes stay asserted through LATCH so prom_d is still valid when sampled.
    assign prom_ce_n    = !((r_state == S_SETUP) || (r_state == S_ACCESS) || (r_state == S_LATCH));
    assign prom_oe_n    = !((r_state == S_ACCESS) || (r_state == S_LATCH));
    assign prom_addr    = r_addr;
    assign busy         = (r_state != S_IDLE);
    assign bus.cpu_dout = r_dout;
    assign bus.dtack_n  = (r_state != S_ACK);
    assign bus.cpu_doe  = (r_state == S_ACK) && !r_wr;
`ifdef BOOTPROM_WRITE_BERR_EN
    assign bus.berr_n   = (r_state != S_BERR);
`else
    assign bus.berr_n   = 1'b1;
`endif

endmodule

// File: tb/tb_bootprom_ctl.sv
// Directed bench for bootprom_ctl: default-timing and fast-timing instances share the CPU bus stimulus.
module tb_bootprom_ctl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        as_n, uds_n, lds_n, rw, psel, sel;
    logic [14:0] addr;
    logic [15:0] pd;
    int          total = 0;
    int          bad   = 0;
    logic [15:0] sb[$];

`ifdef BOOTPROM_WRITE_BERR_EN
    localparam logic EXP_WR_DTACK = 1'b1;
    localparam logic EXP_WR_BERR  = 1'b0;
`else
    localparam logic EXP_WR_DTACK = 1'b0;
    localparam logic EXP_WR_BERR  = 1'b1;
`endif

    bootprom_ctl_if ifa();
    bootprom_ctl_if ifb();

    logic [14:0] pa_a, pa_b;
    logic        ce_a, ce_b, oe_a, oe_b, busy_a, busy_b;

    assign ifa.as_n = as_n;  assign ifb.as_n = as_n;
    assign ifa.uds_n = uds_n; assign ifb.uds_n = uds_n;
    assign ifa.lds_n = lds_n; assign ifb.lds_n = lds_n;
    assign ifa.rw = rw;      assign ifb.rw = rw;
    assign ifa.cpu_addr = addr; assign ifb.cpu_addr = addr;
    assign ifa.prom_sel = psel && !sel;
    assign ifb.prom_sel = psel && sel;

    bootprom_ctl dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa), .prom_addr(pa_a),
        .prom_ce_n(ce_a), .prom_oe_n(oe_a), .prom_d(pd), .busy(busy_a)
    );

    bootprom_ctl #(.WAIT_STATES(1), .SETUP_CLKS(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb), .prom_addr(pa_b),
        .prom_ce_n(ce_b), .prom_oe_n(oe_b), .prom_d(pd), .busy(busy_b)
    );

    wire        w_dtack = sel ? ifb.dtack_n  : ifa.dtack_n;
    wire        w_berr  = sel ? ifb.berr_n   : ifa.berr_n;
    wire        w_doe   = sel ? ifb.cpu_doe  : ifa.cpu_doe;
    wire [15:0] w_dout  = sel ? ifb.cpu_dout : ifa.cpu_dout;
    wire        w_ce    = sel ? ce_b   : ce_a;
    wire        w_oe    = sel ? oe_b   : oe_a;
    wire        w_busy  = sel ? busy_b : busy_a;
    wire [14:0] w_pa    = sel ? pa_b   : pa_a;

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus(input int n);
        @(negedge clk);
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1; psel = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Runs a read up to the acknowledge and checks timing and returned data.
    task automatic do_read(input logic s, input logic [14:0] a, input logic [15:0] d,
                           input int exp_setup, input int exp_ws);
        int   n, setup, oel;
        logic got;
        logic [15:0] e;
        @(negedge clk);
        sel = s; addr = a; pd = d; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0;
        psel = 1'b1; as_n = 1'b0;
        sb.push_back(d);
        n = 0; setup = 0; oel = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            n++;
            if (w_dtack === 1'b0) begin
                got = 1'b1;
            end else begin
                if (w_ce === 1'b0 && w_oe === 1'b1) setup++;
                if (w_oe === 1'b0) oel++;
                if (s) chk("prom_addr_hold", 32'(w_pa), 32'(a));
            end
        end
        chk("dtack_seen", 32'(got), 32'd1);
        chk("latency", n - 1, exp_setup + exp_ws + 1);
        chk("setup_clks", setup, exp_setup);
        chk("oe_low_incl_latch", oel, exp_ws + 1);
        chk("ack_doe", 32'(w_doe), 32'd1);
        chk("ack_ce_released", 32'({w_ce, w_oe}), 32'b11);
        chk("ack_busy", 32'(w_busy), 32'd1);
        e = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
        chk("read_data", 32'(w_dout), 32'(e));
    endtask

    task automatic release_as(input logic [15:0] d);
        @(negedge clk);
        as_n = 1'b1;
        tick();
        chk("rel_dtack", 32'(w_dtack), 32'd1);
        chk("rel_doe", 32'(w_doe), 32'd0);
        chk("rel_busy", 32'(w_busy), 32'd0);
        chk("rel_dout_hold", 32'(w_dout), 32'(d));
    endtask

    initial begin
        reset_n = 1'b0; sel = 1'b0; addr = 15'd0; pd = 16'h0000;
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1; psel = 1'b0;
        #2;
        chk("rst_ce_oe", 32'({ce_a, oe_a}), 32'b11);
        chk("rst_dtack_berr", 32'({ifa.dtack_n, ifa.berr_n}), 32'b11);
        chk("rst_doe_busy", 32'({ifa.cpu_doe, busy_a}), 32'b00);
        chk("rst_dout", 32'(ifa.cpu_dout), 32'h0);
        chk("rst_addr", 32'(pa_a), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        idle_bus(3);

        // Default timing read.
        do_read(1'b0, 15'h0000, 16'h6000, 1, 3);
        release_as(16'h6000);
        idle_bus(2);

        // Fast-timing instance at top address.
        do_read(1'b1, 15'h7FFF, 16'hA5C3, 2, 1);
        release_as(16'hA5C3);
        idle_bus(2);
        sel = 1'b0;
        chk("dout_a_untouched", 32'(ifa.cpu_dout), 32'h6000);

        // Abort on second ACCESS clock.
        @(negedge clk);
        addr = 15'h1234; pd = 16'h1111; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0;
        psel = 1'b1; as_n = 1'b0;
        tick(); tick(); tick();
        chk("abort_in_access", 32'({w_ce, w_oe}), 32'b00);
        @(negedge clk);
        as_n = 1'b1;
        tick();
        chk("abort_strobes", 32'({w_ce, w_oe}), 32'b11);
        chk("abort_busy", 32'(w_busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_dtack", 32'({w_dtack, w_berr}), 32'b11);
        end
        chk("abort_dout_kept", 32'(w_dout), 32'h6000);
        idle_bus(1);

        // Write hit on low byte.
        @(negedge clk);
        rw = 1'b0; uds_n = 1'b1; lds_n = 1'b0; psel = 1'b1; as_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wr_dtack", 32'(w_dtack), 32'(EXP_WR_DTACK));
            chk("wr_berr", 32'(w_berr), 32'(EXP_WR_BERR));
            chk("wr_ce", 32'({w_ce, w_oe, w_doe}), 32'b110);
        end
        @(negedge clk);
        as_n = 1'b1;
        tick();
        chk("wr_release", 32'({w_dtack, w_berr, w_busy}), 32'b110);
        idle_bus(1);

        // No decode hit, and no data strobe: nothing happens.
        @(negedge clk);
        rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; psel = 1'b0; as_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nosel_idle", 32'({w_busy, w_ce, w_dtack}), 32'b011);
        end
        idle_bus(1);
        @(negedge clk);
        uds_n = 1'b1; lds_n = 1'b1; psel = 1'b1; as_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nostrobe_idle", 32'({w_busy, w_ce, w_dtack}), 32'b011);
        end
        idle_bus(1);

        // Held address strobe: a single cycle only, then a fresh read.
        do_read(1'b0, 15'h0ABC, 16'h5A5A, 1, 3);
        @(negedge clk);
        pd = 16'hFFFF;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("held_dtack", 32'({w_dtack, w_ce}), 32'b01);
        end
        chk("held_dout", 32'(w_dout), 32'h5A5A);
        release_as(16'h5A5A);
        do_read(1'b0, 15'h0ABD, 16'h3C3C, 1, 3);
        release_as(16'h3C3C);
        idle_bus(2);

        // Asynchronous reset during ACCESS.
        @(negedge clk);
        addr = 15'h0042; pd = 16'h7777; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0;
        psel = 1'b1; as_n = 1'b0;
        tick(); tick();
        chk("pre_rst_access", 32'({w_ce, w_oe, w_busy}), 32'b001);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_strobes", 32'({w_ce, w_oe}), 32'b11);
        chk("async_rst_ack", 32'({w_dtack, w_doe, w_busy}), 32'b100);
        @(negedge clk);
        reset_n = 1'b1;
        tick(); tick();
        chk("post_rst_idle", 32'({w_busy, w_ce}), 32'b01);
        idle_bus(2);
        do_read(1'b0, 15'h0043, 16'h8001, 1, 3);
        release_as(16'h8001);
        idle_bus(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
